// File: rtl/node_backprop_serial.sv
// node_backprop_serial: ReLU-gated backward pass that streams dA_i = g*W_i and dW_i = g*A_i one pair per handshake
module float_mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [47:0] p;
  logic [22:0] m;
  logic        g, s, up;
  logic [9:0]  e;
  logic [32:0] r;
  // round-to-nearest-even; zero/subnormal inputs and underflow flush to signed zero, overflow saturates to inf
  always_comb begin
    p  = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    m  = p[47] ? p[46:24] : p[45:23];
    g  = p[47] ? p[23] : p[22];
    s  = p[47] ? |p[22:0] : |p[21:0];
    up = g & (s | m[0]);
    e  = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127 + {9'b0, p[47]};
    r  = {e, m} + {32'b0, up};
    y  = (a[30:23] == 8'd0 || b[30:23] == 8'd0 || r[32] || r[32:23] == 10'd0) ? {a[31] ^ b[31], 31'b0}
       : (r[31:23] >= 9'd255) ? {a[31] ^ b[31], 8'hff, 23'b0}
       : {a[31] ^ b[31], r[30:0]};
  end
endmodule

module node_backprop_serial #(
  parameter int                  N_IN    = 5,
  parameter logic [32*N_IN-1:0]  WEIGHTS = '0,
  parameter int                  IDXW    = $clog2(N_IN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          grad_in,
  input  logic [31:0]          z_in,
  input  logic [32*N_IN-1:0]   act_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDXW-1:0]      out_idx,
  output logic [31:0]          dA_out,
  output logic [31:0]          dW_out,
  output logic                 out_last
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [N_IN-1:0][31:0] W = WEIGHTS;
  logic [1:0]             state;
  logic [IDXW-1:0]        idx;
  logic                   open_q, open_in;
  logic [31:0]            g, ma, mw;
  logic [N_IN-1:0][31:0]  act_q;
  assign open_in   = !z_in[31] && z_in[30:0] != 31'd0;
  assign in_ready  = state == IDLE && !rst;
  assign out_valid = state == EMIT;
  float_mult u_da (.a(g), .b(W[idx]),     .y(ma));
  float_mult u_dw (.a(g), .b(act_q[idx]), .y(mw));
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      open_q   <= 1'b0;
      g        <= '0;
      act_q    <= '0;
      dA_out   <= '0;
      dW_out   <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      act_q  <= act_in;
      open_q <= open_in;
      g      <= open_in ? grad_in : 32'h0;
      idx    <= '0;
      state  <= CALC;
    end else if (state == CALC) begin
      dA_out   <= open_q ? ma : 32'h0;
      dW_out   <= open_q ? mw : 32'h0;
      out_idx  <= idx;
      out_last <= idx == IDXW'(N_IN - 1);
      state    <= EMIT;
    end else if (state == EMIT && out_ready) begin
      state <= out_last ? IDLE : CALC;
      idx   <= out_last ? idx : idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_node_backprop_serial.sv
// tb_node_backprop_serial: scoreboard bench with a real-arithmetic reference model for the serial backprop node
module tb_node_backprop_serial;
  localparam int N = 5;
  localparam logic [32*N-1:0] WTS = {32'h3E800000, 32'hBF800000, 32'h40000000, 32'h3F800000, 32'hBF000000};
  logic [31:0] wv [N] = '{32'hBF000000, 32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3E800000};

  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_last;
  logic [31:0] grad_in = 0, z_in = 0, dA_out, dW_out;
  logic [32*N-1:0] act_in = '0;
  logic [2:0] out_idx;

  node_backprop_serial #(.N_IN(N), .WEIGHTS(WTS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .grad_in(grad_in), .z_in(z_in), .act_in(act_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .dA_out(dA_out), .dW_out(dW_out), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] idx; logic [31:0] da; logic [31:0] dw; logic last; } exp_t;
  exp_t q[$];
  int vectors = 0, errors = 0;
  bit rand_ready = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic real s2d(input logic [31:0] x);
    if (x[30:23] == 8'd0) return $bitstoreal({x[31], 63'b0});
    return $bitstoreal({x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] d2s(input real r);
    logic [63:0] b;
    logic [31:0] res;
    int e;
    b = $realtobits(r);
    if (b[62:52] == 11'd0) return {b[63], 31'b0};
    e = int'(b[62:52]) - 1023 + 127;
    if (e <= 0) return {b[63], 31'b0};
    if (e >= 255) return {b[63], 8'hff, 23'b0};
    res = {1'b0, 8'(e), b[51:29]};
    if (b[28:0] > 29'h10000000 || (b[28:0] == 29'h10000000 && b[29])) res = res + 1;
    return {b[63], res[30:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return d2s(s2d(a) * s2d(b));
  endfunction

  function automatic logic [31:0] rf();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // scoreboard: pop on every accepted pair, and demand stable outputs while stalled
  logic [67:0] held;
  bit held_v = 0;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (held_v) chk("stable_under_stall", {28'b0, out_idx, dA_out, dW_out, out_last}, {28'b0, held});
      if (out_ready) begin
        if (q.size() == 0) chk("unexpected_pair", {28'b0, out_idx, dA_out, dW_out, out_last}, 96'hx);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("pair", {28'b0, out_idx, dA_out, dW_out, out_last}, {28'b0, e.idx, e.da, e.dw, e.last});
        end
      end
    end
    held_v = !rst && out_valid && !out_ready;
    held = {out_idx, dA_out, dW_out, out_last};
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = $urandom_range(0, 3) != 0;
  end

  task automatic send(input logic [31:0] gi, input logic [31:0] zi, input logic [31:0] a [N], input bit must_ready);
    int n = 0;
    bit open;
    @(posedge clk); #1;
    in_valid = 1; grad_in = gi; z_in = zi;
    for (int i = 0; i < N; i++) act_in[32*i +: 32] = a[i];
    @(negedge clk); #1;
    if (must_ready) chk("turnaround_in_ready", {95'b0, in_ready}, 96'd1);
    while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (n >= 200) chk("accept_timeout", 96'd0, 96'd1);
    else begin
      open = !zi[31] && zi[30:0] != 0;
      for (int i = 0; i < N; i++)
        q.push_back('{idx: 3'(i), da: open ? fmul(gi, wv[i]) : 32'h0,
                      dw: open ? fmul(gi, a[i]) : 32'h0, last: i == N - 1});
    end
    @(posedge clk); #1;
    in_valid = 0; grad_in = rf(); z_in = rf();
    for (int i = 0; i < N; i++) act_in[32*i +: 32] = rf();
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk); #1;
    while ((q.size() != 0 || !in_ready) && n < 500) begin @(negedge clk); #1; n++; end
    if (n >= 500) chk("done_timeout", 96'd0, 96'd1);
  endtask

  task automatic wait_pair(input int idx);
    int n = 0;
    @(negedge clk); #1;
    while (!(out_valid && out_idx == 3'(idx)) && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) chk("pair_timeout", 96'd0, 96'(idx));
  endtask

  logic [31:0] ones [N] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
  logic [31:0] ra [N];

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {95'b0, in_ready}, 96'd0);
    chk("reset_outputs", {28'b0, out_valid, out_idx, dA_out, dW_out, out_last}, 96'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("ready_after_reset", {95'b0, in_ready}, 96'd1);

    // open gate with first-pair latency
    send(32'h40000000, 32'h3F800000, ones, 0);
    @(negedge clk); #1 chk("calc_cycle_no_valid", {95'b0, out_valid}, 96'd0);
    @(negedge clk); #1 chk("first_pair_latency", {92'b0, out_valid, out_idx}, {92'b0, 1'b1, 3'd0});
    wait_done();
    send(32'h40000000, 32'h00000000, ones, 0);
    wait_done();
    send(32'h40000000, 32'hC0000000, ones, 0);
    wait_done();

    // backpressure on idx 2
    send(32'h40000000, 32'h3F800000, ones, 0);
    wait_pair(1);
    @(posedge clk); #1 out_ready = 0;
    wait_pair(2);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 out_ready = 1;
    @(negedge clk); #1 chk("bp_idx2_at_rise", {92'b0, out_valid, out_idx}, {92'b0, 1'b1, 3'd2});
    @(negedge clk); #1 chk("bp_calc_gap", {95'b0, out_valid}, 96'd0);
    @(negedge clk); #1 chk("bp_idx3_two_later", {92'b0, out_valid, out_idx}, {92'b0, 1'b1, 3'd3});
    wait_done();

    // busy rejection then back-to-back turnaround
    for (int i = 0; i < N; i++) ra[i] = rf();
    send(32'h3FC00000, 32'h3F800000, ra, 0);
    wait_pair(1);
    in_valid = 1; grad_in = 32'h41200000; z_in = 32'h3F800000;
    chk("busy_in_ready", {95'b0, in_ready}, 96'd0);
    @(posedge clk); #1 in_valid = 0;
    wait_pair(4);
    send(32'h80000000, 32'h3F800000, ra, 1);
    wait_done();

    // reset mid-sequence
    send(32'h40000000, 32'h3F800000, ones, 0);
    wait_pair(2);
    rst = 1;
    q.delete();
    @(negedge clk); #1;
    chk("midreset_outputs", {28'b0, out_valid, out_idx, dA_out, dW_out, out_last}, 96'd0);
    chk("midreset_in_ready", {95'b0, in_ready}, 96'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk); #1 chk("ready_after_midreset", {95'b0, in_ready}, 96'd1);
    send(32'h3F000000, 32'h3F800000, ones, 0);
    wait_done();

    // randomized transactions under random backpressure
    rand_ready = 1;
    for (int t = 0; t < 25; t++) begin
      logic [31:0] gr, zr;
      for (int i = 0; i < N; i++) ra[i] = rf();
      gr = ($urandom_range(0, 7) == 0) ? 32'h80000000 : rf();
      case ($urandom_range(0, 3))
        0: zr = 32'h00000000;
        1: zr = 32'h80000000;
        2: zr = {1'b1, rf() | 32'h00800000} ;
        default: zr = {1'b0, rf() | 32'h00800000};
      endcase
      send(gr, zr, ra, 0);
    end
    wait_done();
    rand_ready = 0;
    @(posedge clk); #1 out_ready = 1;
    if (q.size() != 0) chk("leftover_expected", 96'(q.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/node_backprop_serial.md
# node_backprop_serial

Backward-pass companion to the layer-2 ReLU neuron nodes: takes the upstream gradient for one node output plus that node's forward output and input activations, applies the ReLU derivative, and streams out per-input gradients. For each input i it emits dA_i = g·W_i (propagated to the previous layer) and dW_i = g·A_i (weight update), one pair per handshake. It reuses the codebase's combinational `float_mult` and sits between a layer's gradient source and the previous layer's gradient sink.

## Interface
- `N_IN`, 5: number of node inputs/weights.
- `WEIGHTS`, all zeros, width 32*N_IN: IEEE-754 single weights packed, W_i = WEIGHTS[32*i+31:32*i]. Every instantiation overrides it.
- `IDXW`, clog2(N_IN) (3 for default): index width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream transaction valid.
- `in_ready`  out  1  block can accept a transaction.
- `grad_in`  in  32  float dL/dN for this node.
- `z_in`  in  32  float forward output N of this node (post-ReLU).
- `act_in`  in  32*N_IN  forward activations, A_i = act_in[32*i+31:32*i].
- `out_valid`  out  1  output pair valid.
- `out_ready`  in  1  downstream accepts the pair.
- `out_idx`  out  IDXW  input index i of the current pair.
- `dA_out`  out  32  float g·W_i.
- `dW_out`  out  32  float g·A_i.
- `out_last`  out  1  high with the pair for i = N_IN-1.

## Operation
- States: IDLE, CALC, EMIT.
- IDLE: `in_ready`=1. When `in_valid`=1, latch `act_in` and gate flag `open` = (z_in[31]==0 && z_in[30:0]!=0). Latch g = grad_in if `open`, else 32'h0. Set idx=0 and go to CALC.
- CALC (one cycle):
  - If `open`, register dA_out = float_mult(g, W_idx) and dW_out = float_mult(g, A_idx).
  - If not `open`, register 32'h00000000 for both; the multipliers are bypassed.
  - Register out_idx = idx and out_last = (idx == N_IN-1). Go to EMIT.
- EMIT: `out_valid`=1. `dA_out`, `dW_out`, `out_idx` and `out_last` are held stable until `out_valid && out_ready`. On that handshake:
  - If `out_last`, go to IDLE.
  - Otherwise idx += 1 and go to CALC.
- `in_ready` = (state==IDLE) && !rst. `in_valid` outside IDLE is ignored and nothing is latched.
- Latched inputs are not re-sampled during a transaction. Changing `grad_in`, `z_in` or `act_in` mid-sequence has no effect.
- Float arithmetic is exactly `float_mult` behaviour; no rounding or normalisation is added here. A negative-zero gradient passes through unchanged when `open`.

## Timing
- Reset: state=IDLE, idx=0, `out_valid`=0, `dA_out`=0, `dW_out`=0, `out_idx`=0, `out_last`=0. `in_ready`=0 while `rst` is high and 1 on the first cycle after release.
- Accept at edge T. CALC during cycle T+1. `out_valid` is high from T+2.
- Maximum throughput is one pair per 2 cycles. With `out_ready` tied high, a full transaction takes 2·N_IN+1 cycles from accept to `in_ready` high again.
- After the last handshake at edge E, `in_ready`=1 in the cycle following E. A new `in_valid` in that cycle is accepted.
- `rst` mid-transaction abandons the sequence. `out_valid`=0 in the cycle after the reset edge, and no partial sequence resumes.
- `out_ready` held low extends EMIT indefinitely. There is no timeout and no pair is skipped or duplicated.

## Test plan
- Open gate: WEIGHTS = {-0.5, 1.0, 2.0, -1.0, 0.25}, z_in=3F800000, grad_in=40000000, all A_i=3F800000, out_ready=1.
  - Required: dA = BF800000, 40000000, 40800000, C0000000, 3F000000 at idx 0..4.
  - Required: dW = 40000000 for all five pairs, and out_last only on idx 4.
- Closed gate, zero output: same stimulus with z_in=00000000. Required: five pairs with dA=dW=00000000, idx 0..4.
- Closed gate, negative output: z_in=C0000000, grad_in=40000000. Required: all five pairs 00000000.
- Backpressure: out_ready low for 3 cycles while idx=2 is presented.
  - Required: idx/dA/dW stay stable at the idx 2 values.
  - Required: idx 3 is presented 2 cycles after out_ready rises, with no pair lost or repeated.
- Busy rejection and turnaround:
  - Pulse in_valid with different grad_in during EMIT of idx 1. Required: in_ready=0 and output values unaffected.
  - Required: in_ready=1 the cycle after the idx 4 handshake; a back-to-back transaction starts at idx 0.
- Reset mid-sequence: assert rst for 1 cycle at idx 2.
  - Required: out_valid=0 next cycle and all outputs 0.
  - Required: in_ready=1 after release; a fresh transaction emits idx 0 first.
